// File: rtl/ysyx_201979054_muldiv_pkg.sv
// ============================================================================
// Module   : ysyx_201979054_muldiv_pkg
// Purpose  : Shared definitions for the multi-cycle mul/div sequencer:
//            ALU control codes for the M-extension ops it owns (also used by
//            the ALU decoder), the sequencer state type and op-class helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_201979054_muldiv_pkg;

  localparam logic [4:0] ALU_DIVW  = 5'b10011;
  localparam logic [4:0] ALU_MULW  = 5'b10100;
  localparam logic [4:0] ALU_DIVU  = 5'b10101;
  localparam logic [4:0] ALU_DIVUW = 5'b10110;
  localparam logic [4:0] ALU_REMU  = 5'b10111;
  localparam logic [4:0] ALU_REMUW = 5'b11000;
  localparam logic [4:0] ALU_REMW  = 5'b11001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } t_muldiv_state;

  function automatic logic op_valid(input logic [4:0] op);
    case (op)
      ALU_DIVW, ALU_MULW, ALU_DIVU, ALU_DIVUW,
      ALU_REMU, ALU_REMUW, ALU_REMW: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  // W ops iterate WLEN times and sign-extend their result from bit WLEN-1.
  function automatic logic op_is_w(input logic [4:0] op);
    case (op)
      ALU_DIVW, ALU_MULW, ALU_DIVUW, ALU_REMUW, ALU_REMW: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_signed(input logic [4:0] op);
    return (op == ALU_DIVW) || (op == ALU_REMW);
  endfunction

  function automatic logic op_is_rem(input logic [4:0] op);
    return (op == ALU_REMU) || (op == ALU_REMUW) || (op == ALU_REMW);
  endfunction

  function automatic logic op_is_mul(input logic [4:0] op);
    return (op == ALU_MULW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_201979054_div_step.sv
// ============================================================================
// Module   : ysyx_201979054_div_step
// Purpose  : One combinational restoring-division iteration. The next
//            dividend bit is taken from the MSB of the quotient register,
//            shifted into the partial remainder, and the divisor is
//            subtracted when it fits; the fit decision becomes the new
//            quotient LSB.
// Ports    : rem_in  [XLEN] partial remainder before the step
//            q_in    [XLEN] quotient/dividend shift register before the step
//            divisor [XLEN] divisor magnitude
//            rem_out [XLEN] partial remainder after the step
//            q_out   [XLEN] quotient shift register after the step
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_201979054_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] q_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] q_out
);

  // One extra bit: the shifted remainder can exceed XLEN bits when the
  // divisor is larger than 2^(XLEN-1).
  logic [XLEN:0] shifted;
  logic          fits;

  always_comb begin
    shifted = {rem_in, q_in[XLEN-1]};
    fits    = (shifted >= {1'b0, divisor});
    rem_out = fits ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
    q_out   = {q_in[XLEN-2:0], fits};
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_201979054_muldiv_sequencer.sv
// ============================================================================
// Module   : ysyx_201979054_muldiv_sequencer
// Purpose  : Multi-cycle sequencer for MULW, DIVW, DIVU, DIVUW, REMU, REMUW
//            and REMW. Iterative shift-add multiplier and restoring divider,
//            one bit per cycle. IDLE -> CALC (N cycles) -> FIX -> DONE.
// Ports    : i_clk, i_arstn (async, active-low)
//            i_start, i_op[4:0], i_src_a[XLEN], i_src_b[XLEN], i_flush
//            o_ready (IDLE only), o_done (1-cycle pulse), o_result[XLEN],
//            o_illegal (1-cycle pulse for an unknown op)
// Config   : MULDIV_FAST_DIV0_EN - when defined, a divide/remainder with a
//            zero divisor skips the iterations and completes 1 cycle after
//            start. Undefined: the full iteration path produces the same
//            result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_201979054_muldiv_sequencer
  import ysyx_201979054_muldiv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_arstn,
  input  logic            i_start,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal
);

  localparam int CW = $clog2(XLEN);
  localparam int PW = XLEN - WLEN;

  t_muldiv_state state, state_nxt;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem;     // remainder, or product accumulator for MULW
  logic [XLEN-1:0] quo;     // dividend/quotient shift register, or multiplier
  logic [XLEN-1:0] dvs;     // divisor magnitude, or shifting multiplicand
  logic [XLEN-1:0] result;
  logic            w_op, mul_op, rem_op, neg_q, neg_r, illegal;

  logic            accept, bad_op, div0_fast;
  logic            in_w, in_signed, in_mul, b_zero;
  logic [WLEN-1:0] a_w, b_w, a_mag, b_mag;
  logic [XLEN-1:0] fast_result, fix_val, fix_ext, step_rem, step_q;

  // Request decode
  always_comb begin
    in_w      = op_is_w(i_op);
    in_signed = op_is_signed(i_op);
    in_mul    = op_is_mul(i_op);
    a_w       = i_src_a[WLEN-1:0];
    b_w       = i_src_b[WLEN-1:0];
    a_mag     = (in_signed && a_w[WLEN-1]) ? -a_w : a_w;
    b_mag     = (in_signed && b_w[WLEN-1]) ? -b_w : b_w;
    b_zero    = in_w ? (b_w == '0) : (i_src_b == '0);
    // Divide-by-zero answer: quotient all ones, remainder = dividend
    if (op_is_rem(i_op))
      fast_result = in_w ? {{PW{a_w[WLEN-1]}}, a_w} : i_src_a;
    else
      fast_result = '1;
  end

`ifdef MULDIV_FAST_DIV0_EN
  assign div0_fast = !in_mul && b_zero;
`else
  assign div0_fast = 1'b0;
`endif

  ysyx_201979054_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (rem),
    .q_in    (quo),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  // Sign fix-up and W sign extension
  always_comb begin
    if (mul_op)
      fix_val = rem;
    else if (rem_op)
      fix_val = neg_r ? -rem : rem;
    else
      fix_val = neg_q ? -quo : quo;
    fix_ext = w_op ? {{PW{fix_val[WLEN-1]}}, fix_val[WLEN-1:0]} : fix_val;
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bad_op    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start && !i_flush) begin
          if (op_valid(i_op)) begin
            accept    = 1'b1;
            state_nxt = div0_fast ? DONE : CALC;
          end else begin
            bad_op = 1'b1;
          end
        end
      end
      CALC: begin
        if (i_flush)          state_nxt = IDLE;
        else if (cnt == '0)   state_nxt = FIX;
      end
      FIX:     state_nxt = i_flush ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    o_ready = (state == IDLE);
    // A flush in DONE still suppresses the completion pulse.
    o_done  = (state == DONE) && !i_flush;
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      result  <= '0;
      w_op    <= 1'b0;
      mul_op  <= 1'b0;
      rem_op  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      illegal <= bad_op;
      case (state)
        IDLE: begin
          if (accept) begin
            w_op   <= in_w;
            mul_op <= in_mul;
            rem_op <= op_is_rem(i_op);
            neg_q  <= in_signed && (a_w[WLEN-1] ^ b_w[WLEN-1]) && !b_zero;
            neg_r  <= in_signed && a_w[WLEN-1];
            cnt    <= in_w ? CW'(WLEN - 1) : CW'(XLEN - 1);
            rem    <= '0;
            if (in_mul) begin
              quo <= {{PW{1'b0}}, b_w};
              dvs <= {{PW{1'b0}}, a_w};
            end else if (in_w) begin
              // W dividend sits in the top half so every op feeds the
              // divide step from the same MSB position.
              quo <= {a_mag, {PW{1'b0}}};
              dvs <= {{PW{1'b0}}, b_mag};
            end else begin
              quo <= i_src_a;
              dvs <= i_src_b;
            end
            if (div0_fast) result <= fast_result;
          end
        end
        CALC: begin
          if (!i_flush) begin
            if (mul_op) begin
              rem <= rem + (quo[0] ? dvs : '0);
              dvs <= {dvs[XLEN-2:0], 1'b0};
              quo <= {1'b0, quo[XLEN-1:1]};
            end else begin
              rem <= step_rem;
              quo <= step_q;
            end
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          if (!i_flush) result <= fix_ext;
        end
        default: ;
      endcase
    end
  end

  assign o_result  = result;
  assign o_illegal = illegal;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_201979054_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_ysyx_201979054_muldiv_sequencer
// Purpose  : Self-checking bench for the mul/div sequencer. Directed cases,
//            control corners and random operations compared against an
//            arithmetic reference model. Honours MULDIV_FAST_DIV0_EN for
//            expected latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_201979054_muldiv_sequencer;

  localparam logic [4:0] OP_DIVW  = 5'b10011;
  localparam logic [4:0] OP_MULW  = 5'b10100;
  localparam logic [4:0] OP_DIVU  = 5'b10101;
  localparam logic [4:0] OP_DIVUW = 5'b10110;
  localparam logic [4:0] OP_REMU  = 5'b10111;
  localparam logic [4:0] OP_REMUW = 5'b11000;
  localparam logic [4:0] OP_REMW  = 5'b11001;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  op = 5'd0;
  logic [63:0] src_a = '0;
  logic [63:0] src_b = '0;
  logic        ready, done, illegal;
  logic [63:0] result;

  int tests  = 0;
  int failed = 0;
  logic [63:0] last_exp = '0;

  ysyx_201979054_muldiv_sequencer #(.XLEN(64), .WLEN(32)) dut (
    .i_clk     (clk),
    .i_arstn   (arstn),
    .i_start   (start),
    .i_op      (op),
    .i_src_a   (src_a),
    .i_src_b   (src_b),
    .i_flush   (flush),
    .o_ready   (ready),
    .o_done    (done),
    .o_result  (result),
    .o_illegal (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: plain RISC-V arithmetic semantics
  function automatic logic [63:0] model(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, p32;
    logic signed [31:0] sa, sb;
    a32 = a[31:0];
    b32 = b[31:0];
    sa  = $signed(a32);
    sb  = $signed(b32);
    case (o)
      OP_MULW:  begin p32 = a32 * b32; return sx32(p32); end
      OP_DIVU:  return (b == 0) ? '1 : a / b;
      OP_REMU:  return (b == 0) ? a : a % b;
      OP_DIVUW: return (b32 == 0) ? '1 : sx32(a32 / b32);
      OP_REMUW: return (b32 == 0) ? sx32(a32) : sx32(a32 % b32);
      OP_DIVW: begin
        if (b32 == 0) return '1;
        if (sa == 32'sh80000000 && sb == -32'sd1) return sx32(a32);
        p32 = sa / sb;
        return sx32(p32);
      end
      OP_REMW: begin
        if (b32 == 0) return sx32(a32);
        if (sa == 32'sh80000000 && sb == -32'sd1) return '0;
        p32 = sa % sb;
        return sx32(p32);
      end
      default: return '0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [4:0] o, input logic [63:0] b);
    bit w;
    bit bz;
    w  = (o == OP_MULW) || (o == OP_DIVW) || (o == OP_DIVUW) || (o == OP_REMUW) || (o == OP_REMW);
    bz = w ? (b[31:0] == 0) : (b == 0);
`ifdef MULDIV_FAST_DIV0_EN
    if (o != OP_MULW && bz) return 1;
`else
    if (bz) return w ? 34 : 66;
`endif
    return w ? 34 : 66;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for o_done, check result, latency and the
  // return to IDLE. poke=1 raises i_start mid-operation, which must be ignored.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [63:0] a,
                        input logic [63:0] b, input bit poke);
    int lat;
    int elat;
    logic [63:0] exp;
    exp  = model(o, a, b);
    elat = exp_latency(o, b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 3) check({tag, "/busy"}, {63'd0, ready}, 64'd0);
      if (poke && lat == 5) begin
        start = 1'b1; op = OP_DIVU; src_a = 64'd1000; src_b = 64'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check({tag, "/result"}, result, exp);
    check({tag, "/latency"}, 64'(lat), 64'(elat));
    @(posedge clk); #1;
    check({tag, "/idle"}, {62'd0, ready, done}, 64'b10);
    last_exp = exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] optbl [7];
    bit seen_done;
    optbl = '{OP_MULW, OP_DIVW, OP_DIVU, OP_DIVUW, OP_REMU, OP_REMUW, OP_REMW};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset/ready",   {63'd0, ready},   64'd1);
    check("reset/done",    {63'd0, done},    64'd0);
    check("reset/illegal", {63'd0, illegal}, 64'd0);
    check("reset/result",  result,           64'd0);
    @(negedge clk);
    arstn = 1'b1;

    // Directed cases
    run_op("divu_100_7",  OP_DIVU,  64'd100, 64'd7, 1'b0);
    run_op("remu_100_7",  OP_REMU,  64'd100, 64'd7, 1'b0);
    check("divu_100_7/value", model(OP_DIVU, 64'd100, 64'd7), 64'd14);
    run_op("divw_m7_2",   OP_DIVW,  64'hFFFFFFFF_FFFFFFF9, 64'd2, 1'b0);
    run_op("remw_m7_2",   OP_REMW,  64'hFFFFFFFF_FFFFFFF9, 64'd2, 1'b0);
    run_op("divu_div0",   OP_DIVU,  64'd5, 64'd0, 1'b0);
    run_op("remuw_div0",  OP_REMUW, 64'h1_80000000, 64'd0, 1'b0);
    run_op("divw_ovf",    OP_DIVW,  64'h80000000, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    run_op("remw_ovf",    OP_REMW,  64'h80000000, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    run_op("mulw_wrap",   OP_MULW,  64'h10000, 64'h10000, 1'b0);
    run_op("mulw_neg",    OP_MULW,  64'h7FFFFFFF, 64'd2, 1'b0);
    run_op("divu_big",    OP_DIVU,  64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000001, 1'b0);
    run_op("remw_div0",   OP_REMW,  64'h0_8000_0005, 64'h1_0000_0000, 1'b0);

    // Start while busy is ignored
    run_op("busy_poke",   OP_REMU,  64'd123456789, 64'd1000, 1'b1);

    // Illegal op
    @(negedge clk);
    start = 1'b1; op = 5'b00000;
    @(posedge clk); #1;
    start = 1'b0;
    check("illegal/pulse", {63'd0, illegal}, 64'd1);
    check("illegal/ready", {63'd0, ready},   64'd1);
    @(posedge clk); #1;
    check("illegal/clear", {63'd0, illegal}, 64'd0);

    // Flush at CALC cycle 10
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 64'd999; src_b = 64'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush/ready", {63'd0, ready}, 64'd1);
    seen_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("flush/no_done", {63'd0, seen_done}, 64'd0);
    check("flush/result_held", result, last_exp);

    // Flush together with start in IDLE drops the start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_DIVU; src_a = 64'd50; src_b = 64'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start/ready", {63'd0, ready}, 64'd1);

    // Async reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 64'd77; src_b = 64'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    arstn = 1'b0;
    #1;
    check("arst/ready",  {63'd0, ready}, 64'd1);
    check("arst/done",   {63'd0, done},  64'd0);
    check("arst/result", result,         64'd0);
    @(negedge clk);
    arstn = 1'b1;
    run_op("after_arst", OP_DIVU, 64'd77, 64'd4, 1'b0);

    // Random operations
    for (int n = 0; n < 30; n++) begin
      logic [4:0]  ro;
      logic [63:0] ra, rb;
      ro = optbl[$urandom_range(0, 6)];
      ra = {$urandom(), $urandom()};
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = 64'($urandom_range(1, 15));
        2:       rb = {$urandom(), $urandom()};
        3:       rb = {32'd0, $urandom()};
        default: rb = 64'hFFFFFFFF_FFFFFFFF - 64'($urandom_range(0, 9));
      endcase
      if ($urandom_range(0, 3) == 0) ra = {32'($urandom()), 32'h80000000};
      run_op("random", ro, ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
